// File: rtl/wt_dcache_shct_ctrl.sv
// SHCT training-event scheduler: buffers dcache reuse hits and miss-unit evictions and issues them to the predictor.
// Optional statistics counters are enabled with WT_DCACHE_SHCT_STATS_EN.
module wt_dcache_shct_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head
);
  localparam int unsigned AW = $clog2(D);

  logic [D-1:0][W-1:0] mem;
  logic [AW:0]         wr_ptr, rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

module wt_dcache_shct_ctrl #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned SigWidth  = 14,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumPorts-1:0]                hit_valid_i,
  input  logic [NumPorts-1:0][SigWidth-1:0]  hit_sig_i,
  input  logic                               evict_valid_i,
  input  logic [SigWidth-1:0]                evict_sig_i,
  input  logic                               evict_reused_i,
  output logic                               evict_ready_o,
  output logic                               pred_hit_o,
  output logic [SigWidth-1:0]                pred_hit_shct_o,
  output logic                               pred_miss_o,
  output logic [SigWidth-1:0]                pred_miss_shct_o,
  output logic                               pred_outcome_o,
`ifdef WT_DCACHE_SHCT_STATS_EN
  output logic [31:0]                        stat_hit_drop_o,
  output logic [31:0]                        stat_hit_issue_o,
  output logic [31:0]                        stat_evict_issue_o,
`endif
  output logic                               pred_flush_o
);
  localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic {RUN, FLUSH} state_e;
  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i)               state_d = FLUSH;
    else if (state_q == FLUSH) state_d = RUN;
  end

  logic run;
  assign run = (state_q == RUN) && !flush_i;

  // Round-robin pick among hit ports, starting at rr_q.
  logic [PW-1:0] rr_q, win_idx, rr_nxt;
  logic          win_valid;
  int            idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      idx = (int'(rr_q) + i) % int'(NumPorts);
      if (!win_valid && hit_valid_i[idx]) begin
        win_valid = 1'b1;
        win_idx   = PW'(idx);
      end
    end
    rr_nxt = (int'(win_idx) == int'(NumPorts) - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                rr_q <= '0;
    else if (flush_i)           rr_q <= '0;
    else if (run && win_valid)  rr_q <= rr_nxt;
  end

  logic                hit_empty, hit_full, hit_push, hit_issue;
  logic [SigWidth-1:0] hit_head;
  logic                ev_empty, ev_full, ev_push, ev_issue, collide;
  logic [SigWidth:0]   ev_head;

  assign hit_push = run && win_valid && !hit_full;
  assign ev_push  = evict_valid_i && evict_ready_o;

  wt_dcache_shct_fifo #(.W(SigWidth), .D(FifoDepth)) i_hit_fifo (
    .clk_i, .rst_ni, .clr(flush_i), .push(hit_push), .din(hit_sig_i[win_idx]),
    .pop(hit_issue), .empty(hit_empty), .full(hit_full), .head(hit_head)
  );

  wt_dcache_shct_fifo #(.W(SigWidth + 1), .D(FifoDepth)) i_ev_fifo (
    .clk_i, .rst_ni, .clr(flush_i), .push(ev_push), .din({evict_sig_i, evict_reused_i}),
    .pop(ev_issue), .empty(ev_empty), .full(ev_full), .head(ev_head)
  );

  // Same-index collision: hit wins, the eviction head waits a cycle.
  assign hit_issue = run && !hit_empty;
  assign collide   = hit_issue && !ev_empty && (ev_head[SigWidth:1] == hit_head);
  assign ev_issue  = run && !ev_empty && !collide;

  assign evict_ready_o    = run && !ev_full;
  assign pred_hit_o       = hit_issue;
  assign pred_hit_shct_o  = hit_issue ? hit_head : '0;
  assign pred_miss_o      = ev_issue;
  assign pred_miss_shct_o = ev_issue ? ev_head[SigWidth:1] : '0;
  assign pred_outcome_o   = ev_issue && ev_head[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pred_flush_o <= 1'b0;
    else         pred_flush_o <= flush_i;
  end

`ifdef WT_DCACHE_SHCT_STATS_EN
  logic [31:0] drop_cnt;

  always_comb begin
    drop_cnt = '0;
    if (run) begin
      for (int i = 0; i < int'(NumPorts); i++)
        drop_cnt = drop_cnt + {31'd0, hit_valid_i[i]};
      if (hit_push) drop_cnt = drop_cnt - 32'd1;
    end
  end

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_hit_drop_o    <= '0;
      stat_hit_issue_o   <= '0;
      stat_evict_issue_o <= '0;
    end else begin
      stat_hit_drop_o    <= sat_add(stat_hit_drop_o, drop_cnt);
      stat_hit_issue_o   <= sat_add(stat_hit_issue_o, {31'd0, hit_issue});
      stat_evict_issue_o <= sat_add(stat_evict_issue_o, {31'd0, ev_issue});
    end
  end
`endif
endmodule

// File: doc/wt_dcache_shct_ctrl.md
# wt_dcache_shct_ctrl

Training-event scheduler for the write-through dcache SHCT signature predictor. It collects reuse-hit events from the dcache read ports and eviction events from the miss unit, and buffers each in its own small FIFO. Each cycle it drives at most one hit update and one eviction update into the predictor's update ports, resolving same-signature collisions. It sits between the dcache controllers/miss unit and the predictor, and owns the predictor's flush sequencing.

## Interface
- NumPorts, 3, number of dcache read ports producing hit events
- SigWidth, 14, signature width in bits; matches the SHCT index
- FifoDepth, 4, entries per event FIFO; power of two, ≥2

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  cache flush; clears queued training
- hit_valid_i  in  NumPorts  per-port hit-on-reused-line pulse
- hit_sig_i  in  NumPorts×SigWidth  signature of the hit line, per port
- evict_valid_i  in  1  eviction event valid
- evict_sig_i  in  SigWidth  signature of the evicted line
- evict_reused_i  in  1  evicted line was re-referenced while resident
- evict_ready_o  out  1  eviction FIFO can accept
- pred_hit_o  out  1  hit update strobe to predictor
- pred_hit_shct_o  out  SigWidth  hit update signature
- pred_miss_o  out  1  eviction update strobe to predictor
- pred_miss_shct_o  out  SigWidth  eviction update signature
- pred_outcome_o  out  1  reuse flag accompanying pred_miss_o
- pred_flush_o  out  1  flush forwarded to predictor (registered)

## Operation
- States: RUN, FLUSH. Reset state is RUN.
- Hit intake runs in RUN only:
  - A round-robin arbiter over the hit_valid_i bits picks one port per cycle and pushes its signature into the hit FIFO.
  - The RR pointer advances to the port after the winner.
  - Losing ports and pushes while the FIFO is full are dropped. Hits are hints, so there is no backpressure.
- Eviction intake:
  - evict_ready_o = (state==RUN) && eviction FIFO not full.
  - Push happens when evict_valid_i && evict_ready_o. A FIFO entry holds {sig, reused}.
- Issue, every cycle in RUN:
  - Hit FIFO non-empty → pred_hit_o=1 with the head signature; pop.
  - Eviction FIFO non-empty → pred_miss_o=1 with the head {sig, reused}; pop.
- Collision: if both heads are valid and the signatures are equal, issue only the hit. The eviction head stays and issues the next cycle. The predictor can therefore never see the same index written by both ports in one cycle.
- A push and a pop on the same FIFO in the same cycle is legal even when the FIFO is full (occupancy unchanged). A full FIFO with a pop in that cycle still reports not-ready; evict_ready_o is computed from registered occupancy.
- flush_i high in any state:
  - Both FIFOs and the RR pointer are cleared; state goes to FLUSH.
  - No pushes, no issues, evict_ready_o=0.
  - pred_flush_o follows flush_i with one cycle of delay.
- FLUSH → RUN on the first cycle after flush_i has been low for one full cycle. FLUSH therefore lasts (flush_i high cycles + 1).
- All pred_* strobes are 0 outside RUN.

## Timing
- Reset values: every output is 0 except evict_ready_o=1. FIFOs are empty, the RR pointer is 0, state is RUN.
- Reset deasserted mid-operation: all queued events are lost. No partial update is ever issued.
- Latency from event input to predictor strobe is 1 cycle when the FIFO is empty: an accepted push at edge N makes the strobe visible in cycle N+1.
- Issue outputs are driven combinationally from the registered FIFO heads. There is no combinational path from any *_valid_i to any pred_* output.
- Throughput: 1 hit and 1 eviction per cycle, minus collision stalls.
- Pointer wrap: FIFO pointers are log2(FifoDepth)+1 bits; full/empty are decided from the MSB compare.

## Configuration
- WT_DCACHE_SHCT_STATS_EN defined: adds output ports stat_hit_drop_o, stat_hit_issue_o, stat_evict_issue_o, each 32 bits.
  - Each is a saturating counter: it stops at 0xFFFF_FFFF.
  - A drop is counted per dropped port per cycle (arbitration loss or full FIFO).
  - Counters are cleared by reset only, not by flush_i.
- WT_DCACHE_SHCT_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then single hit on port 1, sig 0x0123 → pred_hit_o=1 with pred_hit_shct_o=0x0123 exactly one cycle later, then 0.
- Ports 0, 1, 2 pulse together with sigs A, B, C for 3 cycles, RR pointer at 0 → issue order A(port0), B(port1), C(port2). Six events are dropped; stat_hit_drop_o=6 when WT_DCACHE_SHCT_STATS_EN is defined.
- Push 4 evictions back-to-back while the hit head collides on sig 0x3FFF → evict_ready_o drops to 0 when the FIFO is full. The 0x3FFF eviction issues one cycle after the matching hit, with pred_outcome_o equal to its reused flag.
- Hit and eviction with different sigs 0x0001/0x0002 in the same cycle → pred_hit_o and pred_miss_o both 1 in the next cycle.
- flush_i high for 2 cycles with 3 events queued → no strobes during the flush, pred_flush_o high for 2 cycles delayed by 1, FIFOs empty afterwards, evict_ready_o back to 1 three cycles after flush_i rose.
- Async reset asserted with both FIFOs non-empty → all outputs 0 immediately (evict_ready_o=1). No strobe after release until new events arrive.
